nios_system_debug_scan_master: RTL and testbench

Host-side scan engine that drives the Nios II debug slave's virtual-JTAG pins from the system clock. It accepts one register-access command at a time (IR code plus 38-bit DR payload), generates TCK and the UIR/CDR/SDR/UDR virtual-state strobes, and shifts the payload out on TDI. It captures TDO into a response word and returns it. It sits in the simulation and test harness, and in on-chip debug-master paths, in place of the hub-driven `sld_virtual_jtag_basic` node.

---
 rtl/nios_system_debug_scan_pkg.sv | 21 ++
 rtl/nios_system_debug_scan_tckgen.sv | 43 ++++
 rtl/nios_system_debug_scan_master.sv | 189 ++++++++++++++++++
 tb/tb_nios_system_debug_scan_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_debug_scan_pkg.sv
// Shared types and constants for the Nios II debug scan master.
package nios_system_debug_scan_pkg;

    localparam int DEFAULT_DR_WIDTH = 38;
    localparam int DEFAULT_IR_WIDTH = 2;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_DONE
    } scan_state_e;

endpackage

// File: rtl/nios_system_debug_scan_tckgen.sv
// Free-running TCK divider: low for TCK_DIV clk cycles, then high for TCK_DIV.
module nios_system_debug_scan_tckgen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic tck,
    output logic fall_tick,
    output logic rise_tick
);
    localparam int PERIOD = 2 * TCK_DIV;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] div_q, div_d;
    logic          tck_q, tck_d;

    // Ticks flag the cycle whose closing edge moves TCK, so registered logic
    // elsewhere changes on the same edge as TCK itself.
    always_comb begin
        fall_tick = (div_q == CW'(PERIOD - 1));
        rise_tick = (div_q == CW'(TCK_DIV - 1));
        div_d     = fall_tick ? '0 : div_q + CW'(1);
        tck_d     = tck_q;
        if (rise_tick) begin
            tck_d = 1'b1;
        end else if (fall_tick) begin
            tck_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            tck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            tck_q <= tck_d;
        end
    end

    assign tck = tck_q;

endmodule

// File: rtl/nios_system_debug_scan_master.sv
// Scan engine driving the Nios II debug slave's virtual-JTAG pins from clk:
// one IR/DR access per command, TDO captured into the response word.
module nios_system_debug_scan_master
    import nios_system_debug_scan_pkg::*;
#(
    parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH = DEFAULT_IR_WIDTH,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int CNT_W = $clog2(DR_WIDTH + 1);

    scan_state_e         state_q, state_d;
    logic [IR_WIDTH-1:0] ir_lat_q, ir_lat_d, ir_in_q, ir_in_d;
    logic [DR_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                ir_loaded_q, ir_loaded_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                tdi_q, tdi_d;
    logic                uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d;
    logic                udr_q, udr_d, rti_q, rti_d;
    logic                fall_tick, rise_tick, accept, skip_uir;

    nios_system_debug_scan_tckgen #(
        .TCK_DIV(TCK_DIV)
    ) u_tckgen (
        .clk       (clk),
        .reset_n   (reset_n),
        .tck       (vji_tck),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    assign accept   = cmd_valid && cmd_ready_q;
    // ir_lat_d covers a command accepted in the very cycle we leave IDLE.
    assign skip_uir = ir_loaded_q && (ir_lat_d == ir_in_q);

    always_comb begin
        state_d     = state_q;
        ir_lat_d    = ir_lat_q;
        ir_in_d     = ir_in_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        ir_loaded_d = ir_loaded_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        tdi_d       = tdi_q;

        if (accept) begin
            ir_lat_d    = cmd_ir;
            tx_d        = cmd_data;
            cmd_ready_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fall_tick && (accept || !cmd_ready_q)) begin
                    if (skip_uir) begin
                        state_d   = ST_CDR;
                        bit_cnt_d = CNT_W'(DR_WIDTH - 1);
                    end else begin
                        state_d     = ST_UIR;
                        ir_in_d     = ir_lat_d;
                        ir_loaded_d = 1'b1;
                    end
                end
            end
            ST_UIR: begin
                if (fall_tick) begin
                    state_d   = ST_CDR;
                    bit_cnt_d = CNT_W'(DR_WIDTH - 1);
                end
            end
            ST_CDR: begin
                if (fall_tick) begin
                    state_d = ST_SDR;
                    tdi_d   = tx_q[0];
                end
            end
            ST_SDR: begin
                // TDO settled at the previous falling TCK, so sample at the rise.
                if (rise_tick) begin
                    rx_d = {vji_tdo, rx_q[DR_WIDTH-1:1]};
                end
                if (fall_tick) begin
                    tx_d = tx_q >> 1;
                    if (bit_cnt_q == '0) begin
                        state_d = ST_UDR;
                        tdi_d   = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                        tdi_d     = tx_d[0];
                    end
                end
            end
            ST_UDR: begin
                if (fall_tick) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase

        uir_d = (state_d == ST_UIR);
        cdr_d = (state_d == ST_CDR);
        sdr_d = (state_d == ST_SDR);
        udr_d = (state_d == ST_UDR);
        rti_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ir_lat_q    <= '0;
            ir_in_q     <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            ir_loaded_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            ir_lat_q    <= ir_lat_d;
            ir_in_q     <= ir_in_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            ir_loaded_q <= ir_loaded_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tdi_q       <= tdi_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            udr_q       <= udr_d;
            rti_q       <= rti_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_in_q;
    assign vji_uir   = uir_q;
    assign vji_cdr   = cdr_q;
    assign vji_sdr   = sdr_q;
    assign vji_udr   = udr_q;
    assign vji_rti   = rti_q;

endmodule

// File: tb/tb_nios_system_debug_scan_master.sv
// Bench for the debug scan master: loopback slave, transaction-level model and
// a per-cycle compare process.
module tb_nios_system_debug_scan_master;

    localparam int DRW = 38;
    localparam int IRW = 2;
    localparam int DIV = 2;
    localparam logic [DRW-1:0] PRELOAD = 38'h15_0F0F_F0F0;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [IRW-1:0] cmd_ir = '0;
    logic [DRW-1:0] cmd_data = '0;
    logic           rsp_valid;
    logic [DRW-1:0] rsp_data;
    logic           vji_tck, vji_tdi, vji_tdo;
    logic [IRW-1:0] vji_ir_in;
    logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    int tests_run = 0;
    int tests_failed = 0;
    int timeouts = 0;
    int timeouts_seen = 0;

    nios_system_debug_scan_master #(
        .DR_WIDTH(DRW),
        .IR_WIDTH(IRW),
        .TCK_DIV (DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ir    (cmd_ir),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .vji_tck   (vji_tck),
        .vji_tdi   (vji_tdi),
        .vji_tdo   (vji_tdo),
        .vji_ir_in (vji_ir_in),
        .vji_uir   (vji_uir),
        .vji_cdr   (vji_cdr),
        .vji_sdr   (vji_sdr),
        .vji_udr   (vji_udr),
        .vji_rti   (vji_rti)
    );

    always #5 clk = ~clk;

    // Clk cycles since reset release; TCK must follow this count directly.
    int tb_cyc = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cyc <= 0;
        else          tb_cyc <= tb_cyc + 1;
    end

    // Loopback slave plus per-scan observations taken on TCK edges.
    logic [DRW-1:0] slave_sr = PRELOAD;
    logic           slave_bit = 1'b0;
    logic           slave_pending = 1'b0;
    int             mon_uir = 0;
    int             mon_sdr = 0;
    logic [IRW-1:0] mon_uir_ir = '0;
    logic [DRW-1:0] mon_tdi = '0;

    assign vji_tdo = slave_sr[0];

    always @(posedge vji_tck or negedge vji_tck or negedge reset_n) begin
        if (!reset_n) begin
            slave_sr      = PRELOAD;
            slave_pending = 1'b0;
            mon_uir       = 0;
            mon_sdr       = 0;
            mon_tdi       = '0;
        end else if (vji_tck) begin
            if (vji_rti) begin
                mon_uir = 0;
                mon_sdr = 0;
                mon_tdi = '0;
            end
            if (vji_uir) begin
                mon_uir    = mon_uir + 1;
                mon_uir_ir = vji_ir_in;
            end
            if (vji_sdr) begin
                if (mon_sdr < DRW) mon_tdi[mon_sdr] = vji_tdi;
                mon_sdr       = mon_sdr + 1;
                slave_bit     = vji_tdi;
                slave_pending = 1'b1;
            end
        end else if (slave_pending) begin
            slave_sr      = {slave_bit, slave_sr[DRW-1:1]};
            slave_pending = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run = tests_run + 1;
        if (actual !== expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_rti", vji_rti, 1);
        checkOutput("rst_tck", vji_tck, 0);
        checkOutput("rst_tdi", vji_tdi, 0);
        checkOutput("rst_ir_in", vji_ir_in, 0);
        checkOutput("rst_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr}, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
    endtask

    // Hand-computed expectations per completed response, in order.
    logic [DRW-1:0] lit_rsp [6] = '{38'h15_0F0F_F0F0, 38'h2A_5555_AAAA, 38'h3F_1234_5678,
                                    38'h00_DEAD_BEEF, 38'h01_CAFE_F00D, 38'h15_0F0F_F0F0};
    int             lit_body [6] = '{164, 160, 164, 160, 164, 164};
    int             lit_uir  [6] = '{1, 0, 1, 0, 1, 1};

    // Transaction model state.
    logic           inflight = 1'b0;
    logic           exp_uir = 1'b0;
    logic [IRW-1:0] exp_ir = '0;
    logic [DRW-1:0] exp_data = '0;
    logic [DRW-1:0] exp_rsp = '0;
    logic [DRW-1:0] model_word = PRELOAD;
    logic [IRW-1:0] model_ir = '0;
    logic           model_loaded = 1'b0;
    logic [DRW-1:0] hold_rsp = '0;
    int             body_cnt = 0;
    int             lat = 0;
    logic           lat_done = 1'b0;
    int             rsp_idx = 0;

    always begin
        int  strobes;
        logic body;
        @(negedge clk or negedge reset_n);
        #1;
        if (!reset_n) begin
            inflight     = 1'b0;
            model_word   = PRELOAD;
            model_ir     = '0;
            model_loaded = 1'b0;
            hold_rsp     = '0;
            checkResetValues();
        end else begin
            strobes = int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr) + int'(vji_rti);
            body    = vji_uir | vji_cdr | vji_sdr | vji_udr;
            checkOutput("tck_wave", vji_tck, ((tb_cyc % (2 * DIV)) >= DIV));
            checkOutput("strobe_onehot", strobes, rsp_valid ? 0 : 1);
            checkOutput("cmd_ready", cmd_ready, !inflight);
            if (!vji_sdr) checkOutput("tdi_quiet", vji_tdi, 0);
            if (inflight) begin
                if (!lat_done) begin
                    lat = lat + 1;
                    if (body) begin
                        lat_done = 1'b1;
                        checkOutput("start_latency", (lat >= 1 && lat <= 2 * DIV + 1), 1);
                    end
                end
                if (body) body_cnt = body_cnt + 1;
                if (vji_uir) checkOutput("ir_in_during_uir", vji_ir_in, exp_ir);
                if (rsp_valid) begin
                    hold_rsp = exp_rsp;
                    checkOutput("rsp_data", rsp_data, exp_rsp);
                    checkOutput("uir_periods", mon_uir, exp_uir);
                    if (exp_uir) checkOutput("uir_ir_value", mon_uir_ir, exp_ir);
                    checkOutput("sdr_periods", mon_sdr, DRW);
                    checkOutput("tdi_stream", mon_tdi, exp_data);
                    checkOutput("body_cycles", body_cnt, 2 * DIV * (DRW + (exp_uir ? 3 : 2)));
                    if (rsp_idx < 6) begin
                        checkOutput("lit_rsp", rsp_data, lit_rsp[rsp_idx]);
                        checkOutput("lit_body", body_cnt, lit_body[rsp_idx]);
                        checkOutput("lit_uir", mon_uir, lit_uir[rsp_idx]);
                    end
                    rsp_idx  = rsp_idx + 1;
                    inflight = 1'b0;
                end
            end else begin
                checkOutput("no_rsp_when_idle", rsp_valid, 0);
            end
            checkOutput("rsp_data_held", rsp_data, hold_rsp);
            if (cmd_valid && cmd_ready) begin
                exp_uir      = !(model_loaded && model_ir == cmd_ir);
                exp_ir       = cmd_ir;
                exp_data     = cmd_data;
                exp_rsp      = model_word;
                model_word   = cmd_data;
                model_ir     = cmd_ir;
                model_loaded = 1'b1;
                inflight     = 1'b1;
                lat          = 0;
                lat_done     = 1'b0;
                body_cnt     = 0;
            end
        end
        if (timeouts > timeouts_seen) begin
            checkOutput("wait_bound", timeouts, timeouts_seen);
            timeouts_seen = timeouts;
        end
    end

    // Caller is aligned to posedge+2; returns aligned the same way.
    task automatic applyStimulus(input logic [IRW-1:0] ir, input logic [DRW-1:0] data);
        bit got = 1'b0;
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            #1;
            if (cmd_ready) got = 1'b1;
        end
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        if (!got) timeouts = timeouts + 1;
    endtask

    task automatic waitResponse();
        bit got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) got = 1'b1;
        end
        @(posedge clk);
        #2;
        if (!got) timeouts = timeouts + 1;
    endtask

    initial begin
        bit got;
        #1 reset_n = 1'b0;
        #21 reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #2;

        applyStimulus(2'd2, 38'h2A_5555_AAAA);
        waitResponse();
        applyStimulus(2'd2, 38'h3F_1234_5678);
        waitResponse();
        applyStimulus(2'd0, 38'h00_DEAD_BEEF);
        waitResponse();

        // Second command is presented while the first is still scanning.
        applyStimulus(2'd0, 38'h01_CAFE_F00D);
        applyStimulus(2'd3, 38'h2B_BBBB_0001);
        waitResponse();

        applyStimulus(2'd3, 38'h3C_3C3C_C3C3);
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            #1;
            if (vji_sdr && mon_sdr == 17) got = 1'b1;
        end
        if (!got) timeouts = timeouts + 1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #4 reset_n = 1'b1;
        repeat (120) @(posedge clk);
        #2;

        applyStimulus(2'd0, 38'h07_7777_1111);
        waitResponse();

        repeat (6) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
